// File: rtl/crypto_out_arbiter.sv
// Packet-aware round-robin arbiter sharing one registered result channel between the AES and RSA engines.
// A grant is held for a whole burst: source last, MAX_BURST beats, or IDLE_TO cycles of source silence.
module crypto_out_arbiter #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned MAX_BURST = 65,
    parameter int unsigned IDLE_TO   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [DATA_W-1:0] aes_data_i,
    input  logic              aes_valid_i,
    input  logic              aes_last_i,
    output logic              aes_ready_o,
    input  logic [DATA_W-1:0] rsa_data_i,
    input  logic              rsa_valid_i,
    input  logic              rsa_last_i,
    output logic              rsa_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              out_src_o,
    output logic              out_last_o,
    input  logic              out_ready_i
);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned TO_W   = $clog2(IDLE_TO + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(IDLE_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_G_AES = 2'd1,
        S_G_RSA = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                rr_q, rr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                src_q, src_d;
    logic                last_q, last_d;

    logic                load_en;
    logic                granted;
    logic                side;
    logic                src_valid;
    logic                src_last;
    logic [DATA_W-1:0]   src_data;
    logic                xfer;
    logic                burst_end;

    // Granted-source view shared by the next-state and output logic
    assign load_en   = !stall && (!valid_q || out_ready_i);
    assign granted   = (state_q != S_IDLE);
    assign side      = (state_q == S_G_RSA);
    assign src_valid = side ? rsa_valid_i : aes_valid_i;
    assign src_last  = side ? rsa_last_i  : aes_last_i;
    assign src_data  = side ? rsa_data_i  : aes_data_i;
    assign xfer      = granted && src_valid && load_en;
    assign burst_end = src_last || (beat_q == BEAT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            to_q    <= '0;
            rr_q    <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            to_q    <= to_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    // Grant selection, burst/timeout release; stall freezes everything here
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        to_d    = to_q;
        rr_d    = rr_q;
        if (!stall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (aes_valid_i && (!rsa_valid_i || rr_q)) begin
                        state_d = S_G_AES;
                    end else if (rsa_valid_i) begin
                        state_d = S_G_RSA;
                    end
                end
                default: begin
                    if (xfer) begin
                        to_d = '0;
                        if (burst_end) begin
                            state_d = S_IDLE;
                            rr_d    = side;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end else if (!src_valid) begin
                        if (to_q == TO_LAST) begin
                            state_d = S_IDLE;
                            rr_d    = side;
                            beat_d  = '0;
                            to_d    = '0;
                        end else begin
                            to_d = to_q + TO_W'(1);
                        end
                    end else begin
                        to_d = '0;
                    end
                end
            endcase
        end
    end

    // Source handshakes and output-register loading; the output drains even under stall
    always_comb begin
        aes_ready_o = 1'b0;
        rsa_ready_o = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
        src_d       = src_q;
        last_d      = last_q;
        if (state_q == S_G_AES) aes_ready_o = load_en;
        if (state_q == S_G_RSA) rsa_ready_o = load_en;
        if (xfer) begin
            data_d  = src_data;
            valid_d = 1'b1;
            src_d   = side;
            last_d  = burst_end;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_src_o   = src_q;
    assign out_last_o  = last_q;

endmodule

// File: tb/tb_crypto_out_arbiter.sv
// Bench for crypto_out_arbiter: hand table, directed corner sequences and random traffic vs a burst-level model.
module tb_crypto_out_arbiter;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned MAX_BURST = 65;
    localparam int unsigned IDLE_TO   = 16;
    localparam logic [DATA_W-1:0] AES_W = {4{32'hA5A5_0001}};
    localparam logic [DATA_W-1:0] RSA_W = {4{32'h5A5A_0002}};

    logic              clk = 1'b0;
    logic              rst, stall;
    logic [DATA_W-1:0] aes_data_i, rsa_data_i, out_data_o;
    logic              aes_valid_i, aes_last_i, aes_ready_o;
    logic              rsa_valid_i, rsa_last_i, rsa_ready_o;
    logic              out_valid_o, out_src_o, out_last_o, out_ready_i;

    int checks   = 0;
    int failures = 0;

    // Burst-level reference model
    bit                m_known = 1'b0;
    int                m_owner = -1;
    int                m_beats = 0;
    int                m_idle  = 0;
    int                m_last_served = 1;
    logic [DATA_W-1:0] m_data  = '0;
    bit                m_valid = 1'b0;
    bit                m_src   = 1'b0;
    bit                m_last  = 1'b0;

    crypto_out_arbiter #(
        .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .IDLE_TO(IDLE_TO)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .aes_data_i(aes_data_i), .aes_valid_i(aes_valid_i), .aes_last_i(aes_last_i),
        .aes_ready_o(aes_ready_o),
        .rsa_data_i(rsa_data_i), .rsa_valid_i(rsa_valid_i), .rsa_last_i(rsa_last_i),
        .rsa_ready_o(rsa_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_src_o(out_src_o),
        .out_last_o(out_last_o), .out_ready_i(out_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_load();
        return !stall && (!m_valid || out_ready_i);
    endfunction

    task automatic m_release();
        m_last_served = m_owner;
        m_owner = -1;
        m_beats = 0;
        m_idle  = 0;
    endtask

    task automatic model_tick();
        bit ld, v, l, x;
        logic [DATA_W-1:0] d;
        if (rst) begin
            m_known = 1'b1; m_owner = -1; m_beats = 0; m_idle = 0; m_last_served = 1;
            m_valid = 1'b0; m_src = 1'b0; m_last = 1'b0; m_data = '0;
            return;
        end
        ld = m_load();
        x  = 1'b0;
        if (m_owner < 0) begin
            if (!stall && (aes_valid_i || rsa_valid_i)) begin
                if (aes_valid_i && rsa_valid_i) m_owner = (m_last_served == 1) ? 0 : 1;
                else m_owner = aes_valid_i ? 0 : 1;
            end
        end else if (!stall) begin
            v = (m_owner == 1) ? rsa_valid_i : aes_valid_i;
            l = (m_owner == 1) ? rsa_last_i  : aes_last_i;
            d = (m_owner == 1) ? rsa_data_i  : aes_data_i;
            if (v && ld) begin
                x = 1'b1;
                m_beats++;
                m_data  = d;
                m_valid = 1'b1;
                m_src   = (m_owner == 1);
                m_last  = l || (m_beats == MAX_BURST);
                m_idle  = 0;
                if (m_last) m_release();
            end else if (!v) begin
                m_idle++;
                if (m_idle == IDLE_TO) m_release();
            end else begin
                m_idle = 0;
            end
        end
        if (!x && out_ready_i) m_valid = 1'b0;
    endtask

    // One clock: handshake check before the edge, output check after it
    task automatic step();
        #1;
        if (m_known) begin
            check("aes_ready", aes_ready_o, (m_owner == 0) && m_load());
            check("rsa_ready", rsa_ready_o, (m_owner == 1) && m_load());
        end
        @(posedge clk);
        model_tick();
        #1;
        if (m_known) begin
            check("out_valid", out_valid_o, m_valid);
            check("out_src",   out_src_o,   m_src);
            check("out_last",  out_last_o,  m_last);
            check("out_data",  out_data_o,  m_data);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; aes_valid_i = 1'b0; aes_last_i = 1'b0;
        rsa_valid_i = 1'b0; rsa_last_i = 1'b0; out_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    typedef struct {
        bit rst, stall, av, al, rv, rl, ordy;
        bit chk_rdy, e_ardy, e_rrdy;
        bit e_valid, e_src, e_last;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int outs, last_at, gaps, wait_c, vprob, lprob;

        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, 1'b1,1'b1,1'b1};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b1};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b1};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};

        aes_data_i = AES_W;
        rsa_data_i = RSA_W;
        idle_inputs();
        rst = 1'b1;

        // Hand-computed table: reset, tie-break alternation, backpressure hold, stall drain
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; stall = vecs[i].stall;
            aes_valid_i = vecs[i].av; aes_last_i = vecs[i].al;
            rsa_valid_i = vecs[i].rv; rsa_last_i = vecs[i].rl;
            out_ready_i = vecs[i].ordy;
            #1;
            if (vecs[i].chk_rdy) begin
                check($sformatf("vec%0d_aes_ready", i), aes_ready_o, vecs[i].e_ardy);
                check($sformatf("vec%0d_rsa_ready", i), rsa_ready_o, vecs[i].e_rrdy);
            end
            step();
            check($sformatf("vec%0d_valid", i), out_valid_o, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_src", i),  out_src_o,  vecs[i].e_src);
                check($sformatf("vec%0d_last", i), out_last_o, vecs[i].e_last);
                check($sformatf("vec%0d_data", i), out_data_o, vecs[i].e_src ? RSA_W : AES_W);
            end
        end

        // RSA alone for a forced-release burst of MAX_BURST beats
        do_reset();
        rsa_data_i  = {16{8'h11}};
        rsa_valid_i = 1'b1;
        outs = 0; last_at = 0; gaps = 0;
        for (int c = 0; c < 100 && outs < int'(MAX_BURST); c++) begin
            step();
            if (out_valid_o) begin
                outs++;
                if (out_last_o && last_at == 0) last_at = outs;
                check("burst_src", out_src_o, 1'b1);
            end else if (outs > 0) begin
                gaps++;
            end
        end
        check("burst_len",     outs,    MAX_BURST);
        check("burst_last_at", last_at, MAX_BURST);
        check("burst_gaps",    gaps,    0);
        rsa_valid_i = 1'b0;
        step();
        check("burst_then_idle", out_valid_o, 1'b0);

        // Granted AES goes silent; RSA takes over after the idle timeout, then reset mid-burst
        do_reset();
        aes_data_i = rnd_word();
        aes_valid_i = 1'b1;
        step();
        step();
        check("to_first_word", out_valid_o, 1'b1);
        aes_valid_i = 1'b0;
        rsa_valid_i = 1'b1;
        rsa_data_i  = rnd_word();
        wait_c = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (rsa_ready_o) break;
            wait_c++;
            step();
        end
        check("timeout_wait", wait_c, IDLE_TO + 1);
        for (int c = 0; c < 3; c++) begin
            rsa_data_i = rnd_word();
            step();
        end
        check("rsa_burst_active", out_valid_o, 1'b1);
        rst = 1'b1;
        step();
        check("rst_drops_word", out_valid_o, 1'b0);
        rst = 1'b0;

        // Random traffic in blocks with varying burst length and source activity
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            vprob = (blk % 3 == 2) ? 15 : 70;
            lprob = (blk % 2 == 1) ? 0 : 15;
            for (int c = 0; c < 400; c++) begin
                rst         = ($urandom_range(299) == 0);
                stall       = ($urandom_range(99) < 12);
                out_ready_i = ($urandom_range(99) < 75);
                aes_valid_i = ($urandom_range(99) < vprob);
                rsa_valid_i = ($urandom_range(99) < vprob);
                aes_last_i  = ($urandom_range(99) < lprob);
                rsa_last_i  = ($urandom_range(99) < lprob);
                aes_data_i  = rnd_word();
                rsa_data_i  = rnd_word();
                step();
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
